reg_pipe: RTL
=============

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, bit width of one channel.
REQ-002 Parameter CHANNELS, default 2, number of parallel data channels sharing one handshake.
REQ-003 Parameter DEPTH, default 3, number of register stages; legal range 1..16.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all in-flight beats.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  CHANNELS*WIDTH  same channel packing as in_data.
REQ-013 occupancy  output  clog2(DEPTH+1)  count of valid stages.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold one valid bit v[k] and one CHANNELS*WIDTH data word.
REQ-015 Stage readiness SHALL be r[k] = !v[k] | r[k+1], with r[DEPTH] = out_ready (bubble-collapsing, combinational chain).
REQ-016 in_ready SHALL equal r[0] when flush=0 and rst=0, else 0.
REQ-017 Stage 0 SHALL load in_data and set v[0]=in_valid when r[0]=1; stage k>0 SHALL load stage k-1 data and v[k-1] when r[k]=1; otherwise hold.
REQ-018 out_valid SHALL equal v[DEPTH-1]; out_data SHALL equal stage DEPTH-1 data.
REQ-019 With out_ready held 1 and no flush, a beat accepted at edge t SHALL appear with out_valid=1 in the cycle after edge t+DEPTH-1 (latency DEPTH cycles), throughput one beat per cycle.
REQ-020 Beats SHALL leave in acceptance order; no beat is dropped or duplicated except by flush/rst.
REQ-021 Full (all v=1, out_ready=0): in_ready=0, all stages hold; data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Full with out_ready=1: simultaneous output and input SHALL both occur in one cycle; occupancy unchanged.
REQ-023 Internal bubbles SHALL collapse one stage per cycle under downstream stall.
REQ-024 Channels SHALL be carried bit-exact with no arithmetic; no width extension or truncation.
REQ-025 flush=1 SHALL clear all v[k] at the edge, discard any in_valid beat that cycle, and force out_valid=0 combinationally in that cycle; data registers are don't-care.
REQ-026 occupancy SHALL equal the population count of v[] (registered state, no combinational input path).

Reset
REQ-027 rst=1 at a rising edge SHALL clear all v[k] and all stage data to 0, overriding flush and handshakes.
REQ-028 While rst=1: in_ready=0, out_valid=0, out_data=0, occupancy=0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight beats; first accept possible in the first cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the depth upper bound (16) and a function computing occupancy width clog2(DEPTH+1).
REQ-031 One sub-module reg_pipe_stage (valid bit + data word + load enable) SHALL be instantiated DEPTH times via generate.
REQ-032 No latches; the only storage SHALL be the stage registers.

Verification
REQ-033 Defaults, out_ready=1, beats 0x11_22, 0x33_44, 0x55_66 on consecutive cycles -> identical words on out_data 3 cycles later, consecutive, in order.
REQ-034 out_ready=0, push 4 beats -> 3 accepted, in_ready=0 on 4th, occupancy=3; then out_ready=1 -> 4th accepted same cycle first beat leaves.
REQ-035 Push beat A, idle 2 cycles, push B with out_ready=0 -> bubble collapses, occupancy=2, B immediately behind A at output.
REQ-036 Occupancy 3, flush=1 one cycle with in_valid=1 -> occupancy=0 next cycle, out_valid=0, flushed beat never appears.
REQ-037 rst=1 for one cycle with occupancy 2 -> out_data=0, out_valid=0, occupancy=0; beat pushed next cycle emerges after 3 cycles.
REQ-038 Parameter sweep WIDTH=1/CHANNELS=4/DEPTH=1 and WIDTH=16/CHANNELS=1/DEPTH=16 -> random stream with random out_ready matches scoreboard order.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe register pipeline.
//   MAX_DEPTH  : largest supported number of register stages.
//   occ_width  : bit width needed to count 0..depth valid stages.
package reg_pipe_pkg;

  localparam int MAX_DEPTH = 16;

  // Width of a counter that must represent every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One register stage of reg_pipe: a valid bit plus a data word.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (clears valid and data)
//   flush       : clears the valid bit; data is left as is
//   load        : capture in_valid/in_data this edge, otherwise hold
//   in_valid    : valid bit presented by the previous stage (or upstream)
//   in_data     : data word presented by the previous stage (or upstream)
//   valid, data : registered stage contents
module reg_pipe_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      // Beats are dropped; data contents no longer matter.
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage bubble-collapsing register pipeline carrying
// CHANNELS parallel WIDTH-bit channels under one valid/ready handshake.
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both 1. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready. A producer holds its beat stable until it is accepted.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous drop of every in-flight beat
//   in_valid   : upstream beat present
//   in_ready   : pipeline accepts a beat this cycle
//   in_data    : CHANNELS*WIDTH bits, channel c at [c*WIDTH +: WIDTH]
//   out_valid  : downstream beat present
//   out_ready  : downstream accepts the beat
//   out_data   : same packing as in_data
//   occupancy  : number of valid stages (popcount of the valid bits)
//
// DEPTH is supported over 1..reg_pipe_pkg::MAX_DEPTH.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_ready;
  logic [DW-1:0]    stage_data [DEPTH];
  logic [OCC_W-1:0] occ_count;

  // A stage may load when it is empty or when everything downstream of it
  // can move. Walking from the output back keeps the chain acyclic: the
  // running term is out_ready OR'd with every empty slot seen so far.
  always_comb begin
    logic rdy;
    rdy         = out_ready;
    stage_ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy            = rdy | ~stage_valid[k];
      stage_ready[k] = rdy;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          prev_valid;
    logic [DW-1:0] prev_data;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = in_data;
    end else begin : g_body
      assign prev_valid = stage_valid[k-1];
      assign prev_data  = stage_data[k-1];
    end

    reg_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (stage_ready[k]),
      .in_valid (prev_valid),
      .in_data  (prev_data),
      .valid    (stage_valid[k]),
      .data     (stage_data[k])
    );
  end

  // Popcount of the registered valid bits only.
  always_comb begin
    occ_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_count = occ_count + OCC_W'(stage_valid[k]);
    end
  end

  assign occupancy = occ_count;

  // Flush and reset both block acceptance; a flushed cycle also hides the
  // output beat so nothing is handed off while it is being discarded.
  assign in_ready  = stage_ready[0] & ~flush & ~rst;
  assign out_valid = stage_valid[DEPTH-1] & ~flush & ~rst;
  assign out_data  = rst ? '0 : stage_data[DEPTH-1];

endmodule
